// File: rtl/pc_fetch_unit_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit_if
// Groups the fetch stage's control inputs and its address/status outputs.
//   master : the fetch unit (drives PC, pc_plus4, fetch_pc, inst_valid, fault)
//   slave  : pipeline control / instruction memory side (drives stall,
//            branch_taken, branch_target, jump, jump_target, halt)
// ---------------------------------------------------------------------------
interface pc_fetch_unit_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        jump;
    logic [31:0] jump_target;
    logic        halt;
    logic [31:0] PC;
    logic [31:0] pc_plus4;
    logic [31:0] fetch_pc;
    logic        inst_valid;
    logic        fault;

    modport master (
        input  stall, branch_taken, branch_target, jump, jump_target, halt,
        output PC, pc_plus4, fetch_pc, inst_valid, fault
    );

    modport slave (
        output stall, branch_taken, branch_target, jump, jump_target, halt,
        input  PC, pc_plus4, fetch_pc, inst_valid, fault
    );
endinterface

// File: rtl/pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// pc_fetch_unit
// Program counter and fetch sequencing in front of a one-cycle-latency
// instruction memory. PC is the address the memory registers this edge;
// fetch_pc is the address of the word the memory is presenting now, and
// inst_valid says whether that word may be consumed.
// Ports:
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : pc_fetch_unit_if.master (stall/redirect/halt in, PC/status out)
// Parameters:
//   RESET_PC  : PC after reset (word aligned, below MEM_BYTES)
//   MEM_BYTES : memory size in bytes; sequential PC wraps to 0 here
// ---------------------------------------------------------------------------
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'd0,
    parameter int          MEM_BYTES = 128
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pc_fetch_unit_if.master        bus
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_HALTED = 2'd1,
        ST_FAULT  = 2'd2
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_fetch_pc;
    logic        r_inst_valid;
    logic        r_fault;

    logic [31:0] w_pc_plus4;
    logic [31:0] w_pc_seq;
    logic        w_redirect;
    logic [31:0] w_target;
    logic        w_target_legal;

    assign w_pc_plus4 = r_pc + 32'd4;
    assign w_pc_seq   = (w_pc_plus4 >= MEM_LIMIT) ? 32'd0 : w_pc_plus4;

    // Branch outranks jump when both are raised in the same cycle.
    assign w_redirect     = bus.branch_taken | bus.jump;
    assign w_target       = bus.branch_taken ? bus.branch_target : bus.jump_target;
    assign w_target_legal = (w_target[1:0] == 2'b00) && (w_target < MEM_LIMIT);

    // NOTE: all state is updated with non-blocking assignments so every branch
    // below reads the pre-edge values of r_pc/r_fetch_pc/r_inst_valid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_RUN;
            r_pc         <= RESET_PC;
            r_fetch_pc   <= RESET_PC;
            r_inst_valid <= 1'b0;
            r_fault      <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (bus.halt) begin
                        r_state      <= ST_HALTED;
                        r_inst_valid <= 1'b0;
                    end else if (w_redirect) begin
                        if (w_target_legal) begin
                            // The word read from r_pc this edge is wrong-path:
                            // record its address but mark it invalid.
                            r_pc         <= w_target;
                            r_fetch_pc   <= r_pc;
                            r_inst_valid <= 1'b0;
                        end else begin
                            r_state      <= ST_FAULT;
                            r_fault      <= 1'b1;
                            r_inst_valid <= 1'b0;
                        end
                    end else if (bus.stall) begin
                        if (r_inst_valid && (r_pc == r_fetch_pc)) begin
                            // Memory keeps re-reading the held word; nothing moves.
                        end else if (r_inst_valid) begin
                            // PC already ran ahead: rewind to the stalled word.
                            r_pc         <= r_fetch_pc;
                            r_inst_valid <= 1'b0;
                        end else begin
                            r_fetch_pc   <= r_pc;
                            r_inst_valid <= 1'b1;
                        end
                    end else begin
                        r_fetch_pc   <= r_pc;
                        r_inst_valid <= 1'b1;
                        r_pc         <= w_pc_seq;
                    end
                end
                // Both terminal states freeze everything until reset; inst_valid
                // was already cleared on entry.
                ST_HALTED, ST_FAULT: begin
                    r_inst_valid <= 1'b0;
                end
                default: begin
                    r_state      <= ST_FAULT;
                    r_fault      <= 1'b1;
                    r_inst_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.PC         = r_pc;
    assign bus.pc_plus4   = w_pc_plus4;
    assign bus.fetch_pc   = r_fetch_pc;
    assign bus.inst_valid = r_inst_valid;
    assign bus.fault      = r_fault;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_unit
// Directed scenarios for pc_fetch_unit (RESET_PC=0, MEM_BYTES=128).
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// ---------------------------------------------------------------------------
module tb_pc_fetch_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    pc_fetch_unit_if bus_if ();

    pc_fetch_unit #(
        .RESET_PC  (32'd0),
        .MEM_BYTES (128)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus_if.stall         = 1'b0;
        bus_if.branch_taken  = 1'b0;
        bus_if.branch_target = 32'd0;
        bus_if.jump          = 1'b0;
        bus_if.jump_target   = 32'd0;
        bus_if.halt          = 1'b0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
    endtask

    // Free-run until PC equals target; an expired budget counts as a failure.
    task automatic advance_to_pc(input logic [31:0] target);
        int n;
        n = 0;
        while (bus_if.PC !== target && n < 100) begin
            tick();
            n++;
        end
        checks++;
        if (bus_if.PC !== target) begin
            errors++;
            $display("FAIL advance_to_pc: PC=%0d never reached %0d", bus_if.PC, target);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (bus_if.PC !== 32'd0 || bus_if.fetch_pc !== 32'd0 ||
            bus_if.inst_valid !== 1'b0 || bus_if.fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: PC=%0d fetch_pc=%0d valid=%b fault=%b, want 0/0/0/0",
                     bus_if.PC, bus_if.fetch_pc, bus_if.inst_valid, bus_if.fault);
        end
        checks++;
        if (bus_if.pc_plus4 !== 32'd4) begin
            errors++;
            $display("FAIL reset_pc_plus4: got %0d want 4", bus_if.pc_plus4);
        end
    endtask

    task automatic test_sequential();
        logic [31:0] exp_fetch [3];
        exp_fetch[0] = 32'd0;
        exp_fetch[1] = 32'd4;
        exp_fetch[2] = 32'd8;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus_if.fetch_pc !== exp_fetch[i] || bus_if.inst_valid !== 1'b1 ||
                bus_if.PC !== exp_fetch[i] + 32'd4) begin
                errors++;
                $display("FAIL seq_cycle%0d: fetch_pc=%0d valid=%b PC=%0d, want %0d/1/%0d",
                         i + 1, bus_if.fetch_pc, bus_if.inst_valid, bus_if.PC,
                         exp_fetch[i], exp_fetch[i] + 32'd4);
            end
        end
        advance_to_pc(32'd124);
        checks++;
        if (bus_if.pc_plus4 !== 32'd128) begin
            errors++;
            $display("FAIL pc_plus4_unwrapped: got %0d want 128", bus_if.pc_plus4);
        end
        tick();
        checks++;
        if (bus_if.PC !== 32'd0 || bus_if.fetch_pc !== 32'd124 || bus_if.inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_edge: PC=%0d fetch_pc=%0d valid=%b, want 0/124/1",
                     bus_if.PC, bus_if.fetch_pc, bus_if.inst_valid);
        end
        tick();
        checks++;
        if (bus_if.PC !== 32'd4 || bus_if.fetch_pc !== 32'd0 || bus_if.inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_no_bubble: PC=%0d fetch_pc=%0d valid=%b, want 4/0/1",
                     bus_if.PC, bus_if.fetch_pc, bus_if.inst_valid);
        end
    endtask

    task automatic test_branch_priority();
        do_reset();
        advance_to_pc(32'd12);
        bus_if.branch_taken  = 1'b1;
        bus_if.branch_target = 32'd32;
        bus_if.jump          = 1'b1;
        bus_if.jump_target   = 32'd64;
        tick();
        clear_inputs();
        checks++;
        if (bus_if.inst_valid !== 1'b0 || bus_if.fetch_pc !== 32'd12 || bus_if.PC !== 32'd32) begin
            errors++;
            $display("FAIL branch_bubble: valid=%b fetch_pc=%0d PC=%0d, want 0/12/32",
                     bus_if.inst_valid, bus_if.fetch_pc, bus_if.PC);
        end
        tick();
        checks++;
        if (bus_if.inst_valid !== 1'b1 || bus_if.fetch_pc !== 32'd32 || bus_if.PC !== 32'd36) begin
            errors++;
            $display("FAIL branch_target_word: valid=%b fetch_pc=%0d PC=%0d, want 1/32/36",
                     bus_if.inst_valid, bus_if.fetch_pc, bus_if.PC);
        end
    endtask

    task automatic test_jump();
        do_reset();
        advance_to_pc(32'd12);
        bus_if.jump        = 1'b1;
        bus_if.jump_target = 32'd64;
        bus_if.stall       = 1'b1;   // redirect must override stall
        tick();
        clear_inputs();
        checks++;
        if (bus_if.inst_valid !== 1'b0 || bus_if.fetch_pc !== 32'd12 || bus_if.PC !== 32'd64) begin
            errors++;
            $display("FAIL jump_bubble: valid=%b fetch_pc=%0d PC=%0d, want 0/12/64",
                     bus_if.inst_valid, bus_if.fetch_pc, bus_if.PC);
        end
        tick();
        checks++;
        if (bus_if.inst_valid !== 1'b1 || bus_if.fetch_pc !== 32'd64 || bus_if.PC !== 32'd68) begin
            errors++;
            $display("FAIL jump_target_word: valid=%b fetch_pc=%0d PC=%0d, want 1/64/68",
                     bus_if.inst_valid, bus_if.fetch_pc, bus_if.PC);
        end
    endtask

    task automatic test_stall_replay();
        // Expected {PC, fetch_pc, inst_valid} after each edge:
        // 3 stalled edges (replay, re-present, hold), then 3 free edges.
        logic [31:0] exp_pc    [6];
        logic [31:0] exp_fetch [6];
        logic        exp_valid [6];
        exp_pc[0] = 32'd8;  exp_fetch[0] = 32'd8;  exp_valid[0] = 1'b0;
        exp_pc[1] = 32'd8;  exp_fetch[1] = 32'd8;  exp_valid[1] = 1'b1;
        exp_pc[2] = 32'd8;  exp_fetch[2] = 32'd8;  exp_valid[2] = 1'b1;
        exp_pc[3] = 32'd12; exp_fetch[3] = 32'd8;  exp_valid[3] = 1'b1;
        exp_pc[4] = 32'd16; exp_fetch[4] = 32'd12; exp_valid[4] = 1'b1;
        exp_pc[5] = 32'd20; exp_fetch[5] = 32'd16; exp_valid[5] = 1'b1;
        do_reset();
        advance_to_pc(32'd12);
        for (int i = 0; i < 6; i++) begin
            bus_if.stall = (i < 3);
            tick();
            checks++;
            if (bus_if.PC !== exp_pc[i] || bus_if.fetch_pc !== exp_fetch[i] ||
                bus_if.inst_valid !== exp_valid[i]) begin
                errors++;
                $display("FAIL stall_edge%0d: PC=%0d fetch_pc=%0d valid=%b, want %0d/%0d/%b",
                         i, bus_if.PC, bus_if.fetch_pc, bus_if.inst_valid,
                         exp_pc[i], exp_fetch[i], exp_valid[i]);
            end
        end
        clear_inputs();
    endtask

    task automatic test_fault(input bit use_jump, input logic [31:0] bad_target,
                              input logic [31:0] at_pc);
        do_reset();
        advance_to_pc(at_pc);
        if (use_jump) begin
            bus_if.jump        = 1'b1;
            bus_if.jump_target = bad_target;
        end else begin
            bus_if.branch_taken  = 1'b1;
            bus_if.branch_target = bad_target;
        end
        tick();
        clear_inputs();
        checks++;
        if (bus_if.fault !== 1'b1 || bus_if.inst_valid !== 1'b0 || bus_if.PC !== at_pc) begin
            errors++;
            $display("FAIL fault_entry_%0d: fault=%b valid=%b PC=%0d, want 1/0/%0d",
                     bad_target, bus_if.fault, bus_if.inst_valid, bus_if.PC, at_pc);
        end
        bus_if.stall         = 1'b1;
        bus_if.branch_taken  = 1'b1;
        bus_if.branch_target = 32'd40;
        bus_if.jump          = 1'b1;
        bus_if.jump_target   = 32'd80;
        repeat (3) tick();
        clear_inputs();
        tick();
        checks++;
        if (bus_if.fault !== 1'b1 || bus_if.inst_valid !== 1'b0 || bus_if.PC !== at_pc) begin
            errors++;
            $display("FAIL fault_frozen_%0d: fault=%b valid=%b PC=%0d, want 1/0/%0d",
                     bad_target, bus_if.fault, bus_if.inst_valid, bus_if.PC, at_pc);
        end
        do_reset();
        checks++;
        if (bus_if.fault !== 1'b0 || bus_if.PC !== 32'd0) begin
            errors++;
            $display("FAIL fault_cleared_%0d: fault=%b PC=%0d, want 0/0",
                     bad_target, bus_if.fault, bus_if.PC);
        end
    endtask

    task automatic test_halt();
        do_reset();
        advance_to_pc(32'd20);
        bus_if.halt = 1'b1;
        tick();
        checks++;
        if (bus_if.inst_valid !== 1'b0 || bus_if.PC !== 32'd20 || bus_if.fetch_pc !== 32'd16) begin
            errors++;
            $display("FAIL halt_entry: valid=%b PC=%0d fetch_pc=%0d, want 0/20/16",
                     bus_if.inst_valid, bus_if.PC, bus_if.fetch_pc);
        end
        bus_if.halt          = 1'b0;
        bus_if.branch_taken  = 1'b1;
        bus_if.branch_target = 32'd48;
        repeat (4) tick();
        clear_inputs();
        repeat (2) tick();
        checks++;
        if (bus_if.inst_valid !== 1'b0 || bus_if.PC !== 32'd20 || bus_if.fault !== 1'b0) begin
            errors++;
            $display("FAIL halt_held: valid=%b PC=%0d fault=%b, want 0/20/0",
                     bus_if.inst_valid, bus_if.PC, bus_if.fault);
        end
        do_reset();
        checks++;
        if (bus_if.PC !== 32'd0 || bus_if.inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL halt_reset: PC=%0d valid=%b, want 0/0", bus_if.PC, bus_if.inst_valid);
        end
        tick();
        checks++;
        if (bus_if.fetch_pc !== 32'd0 || bus_if.inst_valid !== 1'b1 || bus_if.PC !== 32'd4) begin
            errors++;
            $display("FAIL halt_resume: fetch_pc=%0d valid=%b PC=%0d, want 0/1/4",
                     bus_if.fetch_pc, bus_if.inst_valid, bus_if.PC);
        end
    endtask

    task automatic test_reset_mid_replay();
        do_reset();
        advance_to_pc(32'd12);
        bus_if.stall = 1'b1;
        tick();
        checks++;
        if (bus_if.PC !== 32'd8 || bus_if.inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL replay_setup: PC=%0d valid=%b, want 8/0", bus_if.PC, bus_if.inst_valid);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        clear_inputs();
        checks++;
        if (bus_if.PC !== 32'd0 || bus_if.fetch_pc !== 32'd0 ||
            bus_if.inst_valid !== 1'b0 || bus_if.fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_replay: PC=%0d fetch_pc=%0d valid=%b fault=%b, want 0/0/0/0",
                     bus_if.PC, bus_if.fetch_pc, bus_if.inst_valid, bus_if.fault);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        clear_inputs();
        test_reset();
        test_sequential();
        test_branch_priority();
        test_jump();
        test_stall_replay();
        test_fault(1'b0, 32'd34, 32'd8);
        test_fault(1'b1, 32'd128, 32'd12);
        test_halt();
        test_reset_mid_replay();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
